array_rw_ctrl: RTL and testbench

Request-side controller for a 256×13 single-port, one-cycle-read-latency SRAM array macro with an RW0 port (`RW0_addr`/`RW0_en`/`RW0_wmode`/`RW0_wdata`/`RW0_rdata`). It accepts independent valid/ready read and write request channels and arbitrates them onto the single SRAM port, with writes taking priority. Read data is captured into an in-order response FIFO with backpressure. An optional post-reset sweep zero-fills the array. The block sits between pipeline logic and the array macro, and replaces ad-hoc direct drive of the RW0 port.

---
 rtl/array_rw_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_array_rw_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_rw_ctrl.sv
// Request-side controller for a single-port, one-cycle-latency SRAM: arbitrates write/read
// channels onto RW0 (writes first) and buffers read data in an in-order response FIFO.
// Define ARRAY_INIT_SWEEP_EN to zero-fill the array after every reset before opening the channels.
module array_rw_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned DATA_W     = 13,
    parameter int unsigned RESP_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              io_w_valid,
    output logic              io_w_ready,
    input  logic [ADDR_W-1:0] io_w_addr,
    input  logic [DATA_W-1:0] io_w_data,

    input  logic              io_r_valid,
    output logic              io_r_ready,
    input  logic [ADDR_W-1:0] io_r_addr,

    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [DATA_W-1:0] io_resp_data,

    output logic              io_init_done,

    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    if (DEPTH != (32'd1 << ADDR_W)) begin : g_depth_check
        $error("array_rw_ctrl: DEPTH must equal 2**ADDR_W");
    end
    if (RESP_DEPTH < 2) begin : g_resp_depth_check
        $error("array_rw_ctrl: RESP_DEPTH must be at least 2");
    end

    logic              init_done;
    logic              sweep_active;
    logic [ADDR_W-1:0] sweep_addr;

`ifdef ARRAY_INIT_SWEEP_EN
    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // The counter parks on the last address; only reset brings it back to 0.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            StInit: begin
                if (sweep_q == LastAddr) begin
                    state_d = StRun;
                end else begin
                    sweep_d = sweep_q + ADDR_W'(1);
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    assign init_done    = (state_q == StRun);
    assign sweep_active = (state_q == StInit);
    assign sweep_addr   = sweep_q;
`else
    assign init_done    = 1'b1;
    assign sweep_active = 1'b0;
    assign sweep_addr   = '0;
`endif

    logic              port_open;
    logic              credit_ok;
    logic              w_fire;
    logic              r_fire;
    logic              inflight_q;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fifo_q [RESP_DEPTH];
    logic              push;
    logic              pop;

    // Reset is asynchronous, so the channels must close combinationally while it is held.
    assign port_open = init_done & ~reset;

    // A read is only issued when its response is guaranteed a FIFO slot.
    assign credit_ok = (32'(count_q) + 32'(inflight_q)) < RESP_DEPTH;

    assign io_init_done = init_done;
    assign io_w_ready   = port_open;
    assign io_r_ready   = port_open & ~io_w_valid & credit_ok;

    assign w_fire = io_w_valid & io_w_ready;
    assign r_fire = io_r_valid & io_r_ready;

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (sweep_active && !reset) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_addr;
        end else if (w_fire) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = io_w_addr;
            sram_wdata = io_w_data;
        end else if (r_fire) begin
            sram_en    = 1'b1;
            sram_addr  = io_r_addr;
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (32'(ptr) == RESP_DEPTH - 1) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign push          = inflight_q;
    assign io_resp_valid = (count_q != '0);
    assign pop           = io_resp_valid & io_resp_ready;
    assign io_resp_data  = fifo_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= r_fire;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Read data is only valid in the cycle after issue, so it is captured unconditionally then.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[tail_q] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_array_rw_ctrl.sv
// Self-checking bench for array_rw_ctrl: behavioural SRAM, expected-content array and a
// response queue that tracks every accepted read with the cycle it was accepted in.
module tb_array_rw_ctrl;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DEPTH      = 256;
    localparam int unsigned DATA_W     = 13;
    localparam int unsigned RESP_DEPTH = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              w_valid = 1'b0;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr = '0;
    logic [DATA_W-1:0] w_data = '0;
    logic              r_valid = 1'b0;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [DATA_W-1:0] resp_data;
    logic              init_done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_en;
    logic              sram_wmode;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    array_rw_ctrl #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_w_valid   (w_valid),
        .io_w_ready   (w_ready),
        .io_w_addr    (w_addr),
        .io_w_data    (w_data),
        .io_r_valid   (r_valid),
        .io_r_ready   (r_ready),
        .io_r_addr    (r_addr),
        .io_resp_valid(resp_valid),
        .io_resp_ready(resp_ready),
        .io_resp_data (resp_data),
        .io_init_done (init_done),
        .sram_addr    (sram_addr),
        .sram_en      (sram_en),
        .sram_wmode   (sram_wmode),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clock = ~clock;

    // Single-port macro with one-cycle read latency; contents are not reset.
    logic [DATA_W-1:0] sram_mem [DEPTH];
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) sram_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= sram_mem[sram_addr];
        end
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        int unsigned       cyc;
    } exp_t;

    exp_t              pq[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int unsigned       cyc = 0;
    int unsigned       n_cmp = 0;
    int unsigned       n_mis = 0;
    bit                exp_init = 1'b0;
    bit                last_r_acc;
    bit                last_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven (posedge+1); sample at negedge, update the model, advance.
    task automatic step();
        bit exp_rr, exp_rv, w_acc, r_acc;
        @(negedge clock);
        exp_rr = exp_init && !w_valid && (pq.size() < RESP_DEPTH);
        exp_rv = (pq.size() > 0) && (pq[0].cyc + 2 <= cyc);
        chk("init_done", init_done, exp_init);
        chk("w_ready", w_ready, exp_init);
        chk("r_ready", r_ready, exp_rr);
        chk("resp_valid", resp_valid, exp_rv);
        if (exp_rv) chk("resp_data", resp_data, pq[0].data);
        w_acc = w_valid && w_ready;
        r_acc = r_valid && r_ready;
        chk("sram_en", sram_en, w_acc || r_acc);
        if (w_acc) begin
            chk("w_wmode", sram_wmode, 1);
            chk("w_addr", sram_addr, w_addr);
            chk("w_wdata", sram_wdata, w_data);
        end else if (r_acc) begin
            chk("r_wmode", sram_wmode, 0);
            chk("r_addr", sram_addr, r_addr);
        end
        last_pop = resp_valid && resp_ready && (pq.size() > 0);
        if (last_pop) void'(pq.pop_front());
        if (r_acc) pq.push_back('{data: ref_mem[r_addr], cyc: cyc});
        if (w_acc) ref_mem[w_addr] = w_data;
        last_r_acc = r_acc;
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic drain();
        w_valid    = 1'b0;
        r_valid    = 1'b0;
        resp_ready = 1'b1;
        for (int k = 0; k < 8 && pq.size() > 0; k++) step();
        chk("drain_empty", pq.size(), 0);
    endtask

`ifdef ARRAY_INIT_SWEEP_EN
    task automatic sweep_check();
        w_valid    = 1'b1;
        r_valid    = 1'b1;
        w_addr     = 8'h55;
        w_data     = '1;
        r_addr     = '0;
        resp_ready = 1'b1;
        exp_init   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            chk("sweep_en", sram_en, 1);
            chk("sweep_wmode", sram_wmode, 1);
            chk("sweep_wdata", sram_wdata, 0);
            chk("sweep_addr", sram_addr, i);
            chk("sweep_init_done", init_done, 0);
            chk("sweep_w_ready", w_ready, 0);
            chk("sweep_r_ready", r_ready, 0);
            chk("sweep_resp_valid", resp_valid, 0);
            @(posedge clock);
            cyc++;
            #1;
        end
        w_valid  = 1'b0;
        r_valid  = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_init = 1'b1;
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned n_acc;
        int          first_pop;
        int          last_pop_k;
        int unsigned n_pop;
        bit          got;

        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_resp_valid", resp_valid, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

`ifdef ARRAY_INIT_SWEEP_EN
        sweep_check();
        r_valid = 1'b1;
        r_addr  = 8'hAB;
        step();
        r_valid = 1'b0;
        drain();
`else
        exp_init = 1'b1;
`endif

        // Preload every address with random data.
        for (int a = 0; a < DEPTH; a++) begin
            w_valid = 1'b1;
            w_addr  = ADDR_W'(a);
            w_data  = DATA_W'($urandom);
            step();
        end
        w_valid = 1'b0;

        // Basic write then read-after-write.
        w_valid = 1'b1; w_addr = 8'h10; w_data = 13'h1ABC;
        step();
        w_valid = 1'b0; r_valid = 1'b1; r_addr = 8'h10;
        step();
        chk("basic_r_acc", last_r_acc, 1);
        r_valid = 1'b0;
        drain();

        // Collision: write wins, read follows next cycle.
        w_valid = 1'b1; w_addr = 8'h20; w_data = 13'h0555;
        r_valid = 1'b1; r_addr = 8'h20;
        step();
        chk("coll_r_blocked", last_r_acc, 0);
        w_valid = 1'b0;
        step();
        chk("coll_r_acc", last_r_acc, 1);
        drain();

        // Backpressure: three credits, the fourth read waits for a pop.
        resp_ready = 1'b0;
        n_acc = 0;
        for (int a = 1; a <= 4; a++) begin
            r_valid = 1'b1;
            r_addr  = ADDR_W'(a);
            got     = 1'b0;
            for (int k = 0; k < 5 && !got; k++) begin
                step();
                got = last_r_acc;
            end
            if (got) n_acc++;
        end
        chk("bp_accepted", n_acc, 3);
        resp_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step();
            got = last_r_acc;
        end
        chk("bp_late_acc", got, 1);
        drain();

        // Streaming: ten back-to-back reads, ten consecutive responses.
        first_pop  = -1;
        last_pop_k = -1;
        n_pop      = 0;
        for (int k = 0; k < 14; k++) begin
            r_valid = (k < 10);
            r_addr  = ADDR_W'(k);
            step();
            if (k < 10) chk("stream_acc", last_r_acc, 1);
            if (last_pop) begin
                n_pop++;
                if (first_pop < 0) first_pop = k;
                last_pop_k = k;
            end
        end
        chk("stream_pops", n_pop, 10);
        chk("stream_span", last_pop_k - first_pop, 9);
        drain();

        // Random traffic over a small address window to hit hazards.
        for (int k = 0; k < 400; k++) begin
            w_valid    = ($urandom_range(0, 3) == 0);
            w_addr     = ADDR_W'($urandom_range(0, 15));
            w_data     = DATA_W'($urandom);
            r_valid    = ($urandom_range(0, 1) == 1);
            r_addr     = ADDR_W'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Mid-operation reset: two buffered, one in flight.
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            r_valid = 1'b1;
            r_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            step();
            chk("mr_r_acc", last_r_acc, 1);
        end
        r_valid = 1'b0;
        w_valid = 1'b1;
        w_addr  = 8'h33;
        w_data  = 13'h0AAA;
        #1;
        chk("mr_pre_valid", resp_valid, 1);
        chk("mr_pre_en", sram_en, 1);
        reset = 1'b1;
        #1;
        chk("mr_resp_valid", resp_valid, 0);
        chk("mr_w_ready", w_ready, 0);
        chk("mr_r_ready", r_ready, 0);
        chk("mr_sram_en", sram_en, 0);
        pq.delete();
        w_valid = 1'b0;
        @(posedge clock);
        cyc++;
        #1;
        reset = 1'b0;
`ifdef ARRAY_INIT_SWEEP_EN
        sweep_check();
`else
        step();
`endif
        r_valid = 1'b1;
        r_addr  = 8'h20;
        step();
        r_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
